// File: rtl/mod13_display_driver_pkg.sv
// Shared constants for the modulo-13 display driver: segment patterns,
// digit FSM state encoding and the largest legal counter value.
package mod13_display_driver_pkg;

    localparam logic [3:0] MOD13_MAX = 4'd12;

    typedef enum logic {
        S_ONES = 1'b0,
        S_TENS = 1'b1
    } state_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/mod13_display_driver_seg7_decoder.sv
// Combinational digit-to-segment decoder producing active-high patterns.
// An out-of-range flag overrides blanking and shows 'E'.
module mod13_display_driver_seg7_decoder
    import mod13_display_driver_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       err,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (err) begin
            pattern = SEG_E;
        end else if (!blank) begin
            case (digit)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/mod13_display_driver.sv
// Two-digit multiplexed seven-segment driver for the modulo-13 counter:
// captures the count once per frame and alternates ones/tens digit slots.
module mod13_display_driver
    import mod13_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_in,
    input  logic       hold,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic       err
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_OFF  = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [PW-1:0] presc_q;
    logic          tick;
    state_t        state_q;
    state_t        state_d;
    logic [3:0]    cap_q;
    logic          err_q;
    logic [3:0]    tens_d;
    logic [3:0]    ones_d;
    logic          cap_oor;
    logic [1:0]    an_hot;
    logic [3:0]    digit_sel;
    logic          blank_sel;
    logic [6:0]    pattern;
    logic [6:0]    seg_q;
    logic [1:0]    an_q;

    assign tick = (presc_q == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ONES;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            state_d = (state_q == S_ONES) ? S_TENS : S_ONES;
        end
    end

    always_comb begin
        an_hot    = 2'b01;
        digit_sel = ones_d;
        blank_sel = 1'b0;
        if (state_q == S_TENS) begin
            an_hot    = 2'b10;
            digit_sel = tens_d;
            blank_sel = BLANK_LZ && (tens_d == 4'd0);
        end
    end

    // The frame boundary is the tick that ends the tens slot; both digits
    // of the following frame are drawn from the same captured value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= 4'd0;
            err_q <= 1'b0;
        end else if (tick && (state_q == S_TENS) && !hold) begin
            cap_q <= count_in;
            err_q <= (count_in > MOD13_MAX);
        end
    end

    always_comb begin
        cap_oor = (cap_q > MOD13_MAX);
        tens_d  = 4'd0;
        ones_d  = cap_q;
        if (!cap_oor && (cap_q >= 4'd10)) begin
            tens_d = 4'd1;
            ones_d = cap_q - 4'd10;
        end
    end

    mod13_display_driver_seg7_decoder u_dec (
        .digit   (digit_sel),
        .blank   (blank_sel),
        .err     (cap_oor),
        .pattern (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= SEG_ACTIVE_LOW ? ~pattern : pattern;
            an_q  <= AN_ACTIVE_LOW ? ~an_hot : an_hot;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    assign err = err_q;

endmodule

// File: tb/tb_mod13_display_driver.sv
// Self-checking bench for mod13_display_driver with REFRESH_DIV=4 and
// default polarities, compared against a frame-level display model.
module tb_mod13_display_driver;

    localparam int RDIV = 4;
    localparam logic [6:0] DIGIT_PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = 4'd0;
    logic       hold = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic       err;

    int checks = 0;
    int failures = 0;

    mod13_display_driver #(
        .REFRESH_DIV    (RDIV),
        .BLANK_LZ       (1'b1),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .hold     (hold),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Display of value v in a slot, as wired (active-low) levels.
    function automatic logic [6:0] model_seg(input int v, input bit tens);
        if (v > 12) return ~7'h79;
        if (tens) return (v / 10 == 0) ? 7'h7F : ~DIGIT_PAT[v / 10];
        return ~DIGIT_PAT[v % 10];
    endfunction

    // Frame-level model: edge k after reset shows slot ((k-1)/RDIV)%2 and
    // the value captured before it; captures land on every 2*RDIV-th edge.
    int         edges = 0;
    int         m_cap = 0;
    logic [6:0] exp_seg = 7'h7F;
    logic [1:0] exp_an = 2'b11;
    logic       exp_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges   <= 0;
            m_cap   <= 0;
            exp_seg <= 7'h7F;
            exp_an  <= 2'b11;
            exp_err <= 1'b0;
        end else begin
            edges   <= edges + 1;
            exp_an  <= (((edges / RDIV) % 2) == 1) ? 2'b01 : 2'b10;
            exp_seg <= model_seg(m_cap, ((edges / RDIV) % 2) == 1);
            if (((edges + 1) % (2 * RDIV) == 0) && !hold) begin
                m_cap   <= int'(count_in);
                exp_err <= (count_in > 4'd12);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h want=7f", seg); end
        if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b want=1", dp); end
        if (an !== 2'b11) begin failures++; $display("FAIL reset_an got=%b want=11", an); end
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (an !== 2'b10) begin failures++; $display("FAIL release_an got=%b want=10", an); end
        if (seg !== 7'h40) begin failures++; $display("FAIL release_seg got=%h want=40", seg); end
    endtask

    task automatic test_value(input logic [3:0] v, input int cycles);
        count_in = v;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checks += 4;
            if (seg !== exp_seg) begin failures++; $display("FAIL value%0d_seg cyc=%0d got=%h want=%h", v, i, seg, exp_seg); end
            if (an !== exp_an) begin failures++; $display("FAIL value%0d_an cyc=%0d got=%b want=%b", v, i, an, exp_an); end
            if (err !== exp_err) begin failures++; $display("FAIL value%0d_err cyc=%0d got=%b want=%b", v, i, err, exp_err); end
            if (dp !== 1'b1) begin failures++; $display("FAIL value%0d_dp got=%b want=1", v, dp); end
        end
    endtask

    task automatic test_hold();
        for (int phase = 0; phase < 3; phase++) begin
            count_in = (phase == 0) ? 4'd5 : 4'd11;
            hold     = (phase == 1);
            for (int i = 0; i < ((phase == 1) ? 6 * RDIV : 4 * RDIV); i++) begin
                @(negedge clk);
                checks += 3;
                if (seg !== exp_seg) begin failures++; $display("FAIL hold%0d_seg cyc=%0d got=%h want=%h", phase, i, seg, exp_seg); end
                if (an !== exp_an) begin failures++; $display("FAIL hold%0d_an cyc=%0d got=%b want=%b", phase, i, an, exp_an); end
                if (err !== exp_err) begin failures++; $display("FAIL hold%0d_err cyc=%0d got=%b want=%b", phase, i, err, exp_err); end
            end
        end
        checks++;
        if (m_cap != 11) begin failures++; $display("FAIL hold_release model_cap=%0d want=11", m_cap); end
        checks++;
        if (seg !== model_seg(11, an == 2'b01)) begin failures++; $display("FAIL hold_release_seg got=%h want=%h", seg, model_seg(11, an == 2'b01)); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        count_in = 4'd13;
        hold = 1'b0;
        for (int i = 0; i < 8 * RDIV && !found; i++) begin
            @(negedge clk);
            if (err === 1'b1 && an === 2'b01) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL midreset_wait got=timeout want=tens_slot_with_err"); end
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (seg !== 7'h7F) begin failures++; $display("FAIL midreset_seg got=%h want=7f", seg); end
        if (an !== 2'b11) begin failures++; $display("FAIL midreset_an got=%b want=11", an); end
        if (err !== 1'b0) begin failures++; $display("FAIL midreset_err got=%b want=0", err); end
        if (dp !== 1'b1) begin failures++; $display("FAIL midreset_dp got=%b want=1", dp); end
        @(negedge clk);
        count_in = 4'd0;
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (an !== 2'b10) begin failures++; $display("FAIL midrelease_an got=%b want=10", an); end
        if (seg !== 7'h40) begin failures++; $display("FAIL midrelease_seg got=%h want=40", seg); end
    endtask

    task automatic test_free_run();
        int ctr = 0;
        int run = 0;
        logic [1:0] prev_an = an;
        bit first_run = 1'b1;
        hold = 1'b0;
        for (int i = 0; i < 30 * RDIV; i++) begin
            count_in = 4'(ctr);
            ctr = (ctr + 1) % 13;
            @(negedge clk);
            checks += 3;
            if (seg !== exp_seg) begin failures++; $display("FAIL freerun_seg cyc=%0d got=%h want=%h", i, seg, exp_seg); end
            if (an !== exp_an) begin failures++; $display("FAIL freerun_an cyc=%0d got=%b want=%b", i, an, exp_an); end
            if (err !== 1'b0) begin failures++; $display("FAIL freerun_err cyc=%0d got=%b want=0", i, err); end
            run++;
            if (an !== prev_an) begin
                if (!first_run) begin
                    checks++;
                    if (run != RDIV) begin failures++; $display("FAIL slot_len got=%0d want=%0d", run, RDIV); end
                end
                first_run = 1'b0;
                run = 0;
                prev_an = an;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checks += 3;
            if (seg !== exp_seg) begin failures++; $display("FAIL random_seg cyc=%0d got=%h want=%h", i, seg, exp_seg); end
            if (an !== exp_an) begin failures++; $display("FAIL random_an cyc=%0d got=%b want=%b", i, an, exp_an); end
            if (err !== exp_err) begin failures++; $display("FAIL random_err cyc=%0d got=%b want=%b", i, err, exp_err); end
            count_in = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_value(4'd7, 4 * RDIV);
        test_value(4'd12, 4 * RDIV);
        test_value(4'd13, 4 * RDIV);
        test_value(4'd0, 4 * RDIV);
        test_hold();
        test_reset_mid();
        test_value(4'd9, 4 * RDIV);
        test_free_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
